en_decode_seq: RTL

Decoding-run sequencer for the stochastic equality-node array. It drives the shared `INIT` line so every node's edge memory is filled with channel bits, then generates the LFSR edge-memory address `EM_SEL` and the decode-clock enable. It runs decoding cycles until the parity checker reports convergence for a programmable number of consecutive cycles or a cycle budget expires, and finally latches the hard decisions. It sits between the top-level host handshake and the EN/PCN fabric.

---
 rtl/en_decode_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/en_decode_seq.sv
// en_decode_seq: decoding-run sequencer for the stochastic equality-node array.
// Fills edge memories (INIT), then gates the decode clock until the parity
// checker has been satisfied for STOP_CNT consecutive cycles or MAX_DC cycles
// have elapsed, and finally latches the hard decisions.
//
// Host handshake: START is a level request sampled only while idle (BUSY=0).
// BUSY rises the cycle after START is taken and stays high through INIT and
// DECODE. DONE is a single-cycle pulse, with BUSY already low, marking the
// end of a completed run. At that point DOUT, EARLY and DC_CNT are valid.
// ABORT ends a run early without any DONE pulse.
module en_decode_seq #(
  parameter int NB       = 16,
  parameter int EM_AW    = 3,
  parameter int N_INIT   = 8,
  parameter int MAX_DC   = 1000,
  parameter int STOP_CNT = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             START,
  input  logic             ABORT,
  input  logic             PARITY_OK,
  input  logic [NB-1:0]    HD,
  output logic             INIT,
  output logic             CLK_D2S_EN,
  output logic [EM_AW-1:0] EM_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic             EARLY,
  output logic [NB-1:0]    DOUT,
  output logic [15:0]      DC_CNT,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_DECODE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  // Feedback tap of the maximal-length polynomial for each legal width.
  localparam int TAP = (EM_AW == 3) ? 1 : 2;
  localparam int IW  = (N_INIT > 1) ? $clog2(N_INIT) : 1;

  localparam logic [IW-1:0]    INIT_LAST = IW'(N_INIT - 1);
  localparam logic [15:0]      DC_LAST   = 16'(MAX_DC - 1);
  localparam logic [7:0]       PR_LAST   = 8'(STOP_CNT - 1);
  localparam logic [EM_AW-1:0] LFSR_SEED = EM_AW'(1);

  state_t           state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic [7:0]       pr_cnt_q, pr_cnt_d;
  logic [15:0]      dc_cnt_q, dc_cnt_d;
  logic             early_q, early_d;
  logic [NB-1:0]    dout_q, dout_d;
  logic [EM_AW-1:0] lfsr_q, lfsr_d;
  logic             init_q, en_q, busy_q, done_q;

  // Next-state, counters, LFSR and result latching.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pr_cnt_d   = pr_cnt_q;
    dc_cnt_d   = dc_cnt_q;
    early_d    = early_q;
    dout_d     = dout_q;
    lfsr_d     = lfsr_q;

    // The address generator runs whenever the fabric is active.
    if (state_q == S_INIT || state_q == S_DECODE) begin
      lfsr_d = {lfsr_q[EM_AW-2:0], lfsr_q[EM_AW-1] ^ lfsr_q[TAP]};
    end

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
          pr_cnt_d   = '0;
          dc_cnt_d   = '0;
          lfsr_d     = LFSR_SEED;
        end
      end
      S_INIT: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else begin
          dc_cnt_d = dc_cnt_q + 16'd1;
          pr_cnt_d = PARITY_OK ? pr_cnt_q + 8'd1 : 8'd0;
          // Early stop has priority over the budget limit.
          if (PARITY_OK && pr_cnt_q == PR_LAST) begin
            state_d = S_FIN;
            early_d = 1'b1;
            dout_d  = HD;
          end else if (dc_cnt_q == DC_LAST) begin
            state_d = S_FIN;
            early_d = 1'b0;
            dout_d  = HD;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and results; control outputs registered from next state.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      init_cnt_q <= '0;
      pr_cnt_q   <= '0;
      dc_cnt_q   <= '0;
      early_q    <= 1'b0;
      dout_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      init_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pr_cnt_q   <= pr_cnt_d;
      dc_cnt_q   <= dc_cnt_d;
      early_q    <= early_d;
      dout_q     <= dout_d;
      lfsr_q     <= lfsr_d;
      init_q     <= (state_d == S_INIT);
      en_q       <= (state_d == S_DECODE);
      busy_q     <= (state_d == S_INIT) || (state_d == S_DECODE);
      done_q     <= (state_d == S_FIN);
    end
  end

  assign INIT       = init_q;
  assign CLK_D2S_EN = en_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign EM_SEL     = lfsr_q;
  assign EARLY      = early_q;
  assign DOUT       = dout_q;
  assign DC_CNT     = dc_cnt_q;
  assign DBG_STATE  = state_q;

endmodule
